// File: rtl/pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline boundary: occupancy states,
// control-bundle field map and default bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int EXMEM_CTRL_W = 15;
    localparam int EXMEM_DATA_W = 16;

    // Control field offsets, LSB first
    localparam int REG_WRITE_BIT      = 0;
    localparam int MEM_READ_BIT       = 1;
    localparam int MEM_WRITE_BIT      = 2;
    localparam int REG_DIST_LSB       = 3;
    localparam int WB_MUX_LSB         = 5;
    localparam int MEM_SRC_LSB        = 8;
    localparam int STACK_PUSH_MUX_LSB = 10;
    localparam int STACK_POP_MUX_BIT  = 12;
    localparam int STACK_PUSH_BIT     = 13;
    localparam int STACK_POP_BIT      = 14;

    typedef struct packed {
        logic       stack_pop;
        logic       stack_push;
        logic       stack_pop_mux;
        logic [1:0] stack_push_mux;
        logic [1:0] mem_src;
        logic [2:0] wb_mux;
        logic [1:0] reg_dist;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } exmem_ctrl_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline slot holding {valid, ctrl, data}. Clear wins over load and
// always zeroes ctrl so an invalid slot never leaks control bits downstream.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EXMEM_CTRL_W,
    parameter int DATA_W = EXMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              zero_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot storage: reset, then clear, then load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{1'b0}};
            data  <= {DATA_W{1'b0}};
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= {CTRL_W{1'b0}};
            if (zero_data) begin
                data <= {DATA_W{1'b0}};
            end else begin
                data <= data;
            end
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else begin
            valid <= valid;
            ctrl  <= ctrl;
            data  <= data;
        end
    end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM pipeline boundary with valid/ready handshake, flush and an optional
// two-entry skid buffer that makes in_ready a flop.
module ex_mem_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W            = EXMEM_DATA_W,
    parameter int CTRL_W            = EXMEM_CTRL_W,
    parameter int SKID              = 1,
    parameter int CLR_DATA_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_t      state;
    stage_state_t      next_state;
    logic              accept;
    logic              consume;
    logic              main_load;
    logic              main_clear;
    logic              main_zero;
    logic              main_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_in_data;

    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign occupancy = state;

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next state and entry load/clear strobes; flush overrides every transition
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_zero      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
            main_clear = 1'b1;
            main_zero  = (CLR_DATA_ON_FLUSH != 0);
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state = ST_ONE;
                        main_load  = 1'b1;
                    end else begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        // Without a skid slot accept implies consume; this arm only fires with SKID
                        if (SKID != 0) begin
                            next_state = ST_TWO;
                            skid_load  = 1'b1;
                        end else begin
                            main_load = 1'b1;
                        end
                    end else if (consume) begin
                        next_state = ST_EMPTY;
                        main_clear = 1'b1;
                    end else begin
                        next_state = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        next_state     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end else begin
                        next_state = ST_TWO;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_in_ctrl = (main_from_skid && skid_valid) ? skid_ctrl : in_ctrl;
    assign main_in_data = (main_from_skid && skid_valid) ? skid_data : in_data;

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clear     (main_clear),
        .zero_data (main_zero),
        .in_ctrl   (main_in_ctrl),
        .in_data   (main_in_data),
        .valid     (out_valid),
        .ctrl      (out_ctrl),
        .data      (out_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .clear     (skid_clear),
                .zero_data (main_zero),
                .in_ctrl   (in_ctrl),
                .in_data   (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );

            // Registered ready: refuse only once both slots will be occupied
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (next_state != ST_TWO);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = {CTRL_W{1'b0}};
            assign skid_data  = {DATA_W{1'b0}};
            assign in_ready   = ~out_valid | out_ready;
        end
    endgenerate

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Directed bench: SKID=1 instance for reset/stream/backpressure/flush/bubbles,
// SKID=0 instance (data zeroed on flush) for combinational ready and replace.
module tb_ex_mem_stage_buf;

    localparam int CW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;

    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occupancy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLR_DATA_ON_FLUSH(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
    );

    ex_mem_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLR_DATA_ON_FLUSH(1)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_ctrl(in_ctrl0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occupancy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 1'b0;
        #12;
        check("rst_valid",  32'(out_valid), 32'(1'b0));
        check("rst_ctrl",   32'(out_ctrl),  32'(15'h0000));
        check("rst_data",   32'(out_data),  32'(16'h0000));
        check("rst_occ",    32'(occupancy), 32'(2'd0));
        check("rst_ready",  32'(in_ready),  32'(1'b1));
        check("rst_ready0", 32'(in_ready0), 32'(1'b1));
        rst = 1'b0;
        cyc();

        // Streaming, one-cycle latency
        in_ctrl = 15'h0800; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 16'(i);
            cyc();
            check("str_valid", 32'(out_valid), 32'(1'b1));
            check("str_data",  32'(out_data),  32'(i));
            check("str_ctrl",  32'(out_ctrl),  32'(15'h0800));
            check("str_ready", 32'(in_ready),  32'(1'b1));
            check("str_occ",   32'(occupancy), 32'(2'd1));
        end
        in_valid = 1'b0;
        cyc();
        check("str_drain_valid", 32'(out_valid), 32'(1'b0));
        check("str_drain_ctrl",  32'(out_ctrl),  32'(15'h0000));
        check("str_drain_occ",   32'(occupancy), 32'(2'd0));

        // Backpressure into the skid slot
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h00A1; in_ctrl = 15'h4001;
        cyc();
        check("bp1_occ",   32'(occupancy), 32'(2'd1));
        check("bp1_data",  32'(out_data),  32'(16'h00A1));
        check("bp1_ctrl",  32'(out_ctrl),  32'(15'h4001));
        check("bp1_ready", 32'(in_ready),  32'(1'b1));
        in_data = 16'h00A2; in_ctrl = 15'h2AAA;
        cyc();
        check("bp2_occ",   32'(occupancy), 32'(2'd2));
        check("bp2_ready", 32'(in_ready),  32'(1'b0));
        check("bp2_data",  32'(out_data),  32'(16'h00A1));
        check("bp2_ctrl",  32'(out_ctrl),  32'(15'h4001));
        in_data = 16'h00A3; in_ctrl = 15'h7FFF;
        cyc();
        check("bp3_occ",   32'(occupancy), 32'(2'd2));
        check("bp3_hold",  32'(out_data),  32'(16'h00A1));
        check("bp3_ready", 32'(in_ready),  32'(1'b0));
        out_ready = 1'b1;
        cyc();
        check("bp4_data",  32'(out_data),  32'(16'h00A2));
        check("bp4_ctrl",  32'(out_ctrl),  32'(15'h2AAA));
        check("bp4_occ",   32'(occupancy), 32'(2'd1));
        check("bp4_ready", 32'(in_ready),  32'(1'b1));
        cyc();
        check("bp5_data",  32'(out_data),  32'(16'h00A3));
        check("bp5_ctrl",  32'(out_ctrl),  32'(15'h7FFF));
        check("bp5_occ",   32'(occupancy), 32'(2'd1));
        in_valid = 1'b0;
        cyc();
        check("bp6_occ",   32'(occupancy), 32'(2'd0));
        check("bp6_valid", 32'(out_valid), 32'(1'b0));

        // Flush at occupancy 2 with input offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h00B1; in_ctrl = 15'h0011;
        cyc();
        in_data = 16'h00B2; in_ctrl = 15'h0022;
        cyc();
        check("fl_pre_occ", 32'(occupancy), 32'(2'd2));
        flush = 1'b1; in_data = 16'h00B3; in_ctrl = 15'h0033;
        cyc();
        check("fl_valid", 32'(out_valid), 32'(1'b0));
        check("fl_ctrl",  32'(out_ctrl),  32'(15'h0000));
        check("fl_occ",   32'(occupancy), 32'(2'd0));
        check("fl_ready", 32'(in_ready),  32'(1'b1));
        check("fl_data",  32'(out_data),  32'(16'h00B1));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        check("fl_after_valid", 32'(out_valid), 32'(1'b0));
        check("fl_after_occ",   32'(occupancy), 32'(2'd0));

        // Flush at occupancy 1 while the offered word is accepted
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h00C1; in_ctrl = 15'h0044;
        cyc();
        check("fl1_pre_occ", 32'(occupancy), 32'(2'd1));
        flush = 1'b1; in_data = 16'h00C2; in_ctrl = 15'h0055;
        cyc();
        check("fl1_valid", 32'(out_valid), 32'(1'b0));
        check("fl1_occ",   32'(occupancy), 32'(2'd0));
        flush = 1'b0; in_valid = 1'b0;
        cyc();
        check("fl1_after_valid", 32'(out_valid), 32'(1'b0));
        check("fl1_after_data",  32'(out_data),  32'(16'h00C1));

        // Bubble gating
        in_valid = 1'b0; in_ctrl = 15'h7FFF; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bub_valid", 32'(out_valid), 32'(1'b0));
            check("bub_ctrl",  32'(out_ctrl),  32'(15'h0000));
        end

        // Asynchronous reset with two entries held
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h00D1; in_ctrl = 15'h0101;
        cyc();
        in_data = 16'h00D2;
        cyc();
        check("mrst_pre_occ", 32'(occupancy), 32'(2'd2));
        rst = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 32'(1'b0));
        check("mrst_ctrl",  32'(out_ctrl),  32'(15'h0000));
        check("mrst_data",  32'(out_data),  32'(16'h0000));
        check("mrst_occ",   32'(occupancy), 32'(2'd0));
        check("mrst_ready", 32'(in_ready),  32'(1'b1));
        in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("mrst_after_valid", 32'(out_valid), 32'(1'b0));
        check("mrst_after_occ",   32'(occupancy), 32'(2'd0));

        // SKID=0: combinational ready and replace-in-one-edge
        out_ready0 = 1'b0; in_valid0 = 1'b1;
        in_data0 = 16'h00E1; in_ctrl0 = 15'h0155;
        cyc();
        check("s0_valid", 32'(out_valid0), 32'(1'b1));
        check("s0_data",  32'(out_data0),  32'(16'h00E1));
        check("s0_occ",   32'(occupancy0), 32'(2'd1));
        check("s0_full",  32'(in_ready0),  32'(1'b0));
        in_data0 = 16'h00E2; in_ctrl0 = 15'h02AA; out_ready0 = 1'b1;
        #1;
        check("s0_comb_ready", 32'(in_ready0), 32'(1'b1));
        cyc();
        check("s0_repl_data", 32'(out_data0),  32'(16'h00E2));
        check("s0_repl_ctrl", 32'(out_ctrl0),  32'(15'h02AA));
        check("s0_repl_occ",  32'(occupancy0), 32'(2'd1));
        flush0 = 1'b1; in_data0 = 16'h00E3;
        cyc();
        check("s0_fl_valid", 32'(out_valid0), 32'(1'b0));
        check("s0_fl_data",  32'(out_data0),  32'(16'h0000));
        check("s0_fl_ctrl",  32'(out_ctrl0),  32'(15'h0000));
        check("s0_fl_occ",   32'(occupancy0), 32'(2'd0));
        flush0 = 1'b0; in_valid0 = 1'b0;
        cyc();
        check("s0_after_valid", 32'(out_valid0), 32'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
